// File: rtl/brew_timer_pkg.sv
// brew_timer_pkg: shared state encoding, framebuffer commands and defaults
// for the brew timer.
package brew_timer_pkg;

    localparam int STATE_W         = 2;
    localparam int FB_BITS_DEFAULT = 384;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        BREW  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Commands the FSM issues to the framebuffer owner
    typedef enum logic [1:0] {
        FB_HOLD   = 2'd0,
        FB_CLEAR  = 2'd1,
        FB_SHIFT  = 2'd2,
        FB_INVERT = 2'd3
    } fb_cmd_e;

endpackage

// File: rtl/brew_timer_fb.sv
// brew_timer_fb: owns the LED framebuffer. The timer FSM issues one command
// per cycle: clear, shift a lit LED in at bit 0, invert (blink) or hold.
module brew_timer_fb
    import brew_timer_pkg::*;
#(
    parameter int FB_BITS = FB_BITS_DEFAULT
) (
    input  logic               clk,
    input  logic               nrst,
    input  fb_cmd_e            cmd,
    output logic [FB_BITS-1:0] framebuf
);

    // Apply the FSM command to the framebuffer image
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            framebuf <= '0;
        end else begin
            case (cmd)
                FB_CLEAR:  framebuf <= '0;
                FB_SHIFT:  framebuf <= {framebuf[FB_BITS-2:0], 1'b1};
                FB_INVERT: framebuf <= ~framebuf;
                default:   framebuf <= framebuf;
            endcase
        end
    end

endmodule

// File: rtl/brew_timer.sv
// brew_timer: 1 Hz brew timer with runtime-selectable duration, a
// thermometer progress bar, end-of-brew blink and a one-cycle done pulse.
// Optional pause/resume is built only when BREW_TIMER_PAUSE_EN is defined;
// otherwise sw_pause is kept as a pin but ignored.
module brew_timer
    import brew_timer_pkg::*;
#(
    parameter int FB_BITS      = FB_BITS_DEFAULT,
    parameter int CNT_W        = 9,
    parameter int DEFAULT_SECS = 240
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               sw_start,
    input  logic               sw_stop,
    input  logic               sw_pause,
    input  logic [CNT_W-1:0]   brew_secs,
    output logic [FB_BITS-1:0] framebuf,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   remaining,
    output logic               done_pulse
);

    localparam logic [CNT_W-1:0] MAX_SECS = CNT_W'(FB_BITS);
    localparam logic [CNT_W-1:0] DEF_SECS = CNT_W'(DEFAULT_SECS);

    state_e           state_q;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] start_target;
    logic [CNT_W-1:0] elapsed_inc;
    logic             pause_req;
    fb_cmd_e          fb_cmd;

`ifdef BREW_TIMER_PAUSE_EN
    assign pause_req = sw_pause;
`else
    logic unused_pause;
    assign unused_pause = sw_pause;
    assign pause_req    = 1'b0;
`endif

    assign state       = state_q;
    assign elapsed_inc = elapsed + 1'b1;

    // Clamp the requested duration: 0 selects the default, overlong runs
    // are capped at the bar length so the counters can never overrun it
    always_comb begin
        start_target = brew_secs;
        if (brew_secs == '0)
            start_target = DEF_SECS;
        else if (brew_secs > MAX_SECS)
            start_target = MAX_SECS;
    end

    // Framebuffer command follows the same priority as the FSM below
    always_comb begin
        fb_cmd = FB_HOLD;
        if (sw_stop || sw_start) begin
            fb_cmd = FB_CLEAR;
        end else begin
            case (state_q)
                BREW:    fb_cmd = pause_req ? FB_HOLD : FB_SHIFT;
                DONE:    fb_cmd = FB_INVERT;
                default: fb_cmd = FB_HOLD;
            endcase
        end
    end

    // Timer FSM: stop > start > pause > normal progression
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            elapsed    <= '0;
            target     <= '0;
            remaining  <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (sw_stop) begin
                state_q   <= IDLE;
                elapsed   <= '0;
                target    <= '0;
                remaining <= '0;
            end else if (sw_start) begin
                state_q   <= BREW;
                elapsed   <= '0;
                target    <= start_target;
                remaining <= start_target;
            end else begin
                case (state_q)
                    BREW: begin
                        if (pause_req) begin
                            state_q <= PAUSE;
                        end else begin
                            elapsed   <= elapsed_inc;
                            remaining <= remaining - 1'b1;
                            if (elapsed_inc == target) begin
                                state_q    <= DONE;
                                done_pulse <= 1'b1;
                            end
                        end
                    end
`ifdef BREW_TIMER_PAUSE_EN
                    PAUSE: begin
                        if (pause_req)
                            state_q <= BREW;
                    end
`endif
                    DONE: begin
                        remaining <= '0;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    brew_timer_fb #(
        .FB_BITS (FB_BITS)
    ) u_fb (
        .clk      (clk),
        .nrst     (nrst),
        .cmd      (fb_cmd),
        .framebuf (framebuf)
    );

endmodule

// File: tb/tb_brew_timer.sv
// tb_brew_timer: directed, self-checking bench for brew_timer with
// hand-computed expectations. Pause expectations follow BREW_TIMER_PAUSE_EN.
module tb_brew_timer;

    localparam int FB_BITS = 384;
    localparam int CNT_W   = 9;

    logic               clk = 1'b0;
    logic               nrst;
    logic               sw_start, sw_stop, sw_pause;
    logic [CNT_W-1:0]   brew_secs;
    logic [FB_BITS-1:0] framebuf;
    logic [1:0]         state;
    logic [CNT_W-1:0]   remaining;
    logic               done_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    logic [FB_BITS-1:0] ones;
    logic [FB_BITS-1:0] bar7;

    brew_timer #(
        .FB_BITS      (FB_BITS),
        .CNT_W        (CNT_W),
        .DEFAULT_SECS (240)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sw_start   (sw_start),
        .sw_stop    (sw_stop),
        .sw_pause   (sw_pause),
        .brew_secs  (brew_secs),
        .framebuf   (framebuf),
        .state      (state),
        .remaining  (remaining),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FB_BITS-1:0] got,
                       input logic [FB_BITS-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st,
                           input int rem, input logic dp);
        chk({tag, ".state"}, FB_BITS'(state), FB_BITS'(st));
        chk({tag, ".rem"}, FB_BITS'(remaining), FB_BITS'(rem));
        chk({tag, ".done"}, FB_BITS'(done_pulse), FB_BITS'(dp));
    endtask

    initial begin
        ones = '1;
        bar7 = FB_BITS'(7);
        nrst = 1'b0; sw_start = 0; sw_stop = 0; sw_pause = 0; brew_secs = '0;
        #3;
        chk_out("reset", 2'd0, 0, 1'b0);
        chk("reset.fb", framebuf, '0);
        @(negedge clk);
        nrst = 1'b1;

        // 3-second brew: bar grows 1,3,7 then DONE with one-cycle pulse
        brew_secs = 9'd3; sw_start = 1; tick(); sw_start = 0;
        chk_out("s3.t0", 2'd1, 3, 1'b0);
        chk("s3.t0.fb", framebuf, '0);
        tick(); chk("s3.t1.fb", framebuf, FB_BITS'(1)); chk_out("s3.t1", 2'd1, 2, 1'b0);
        tick(); chk("s3.t2.fb", framebuf, FB_BITS'(3)); chk_out("s3.t2", 2'd1, 1, 1'b0);
        tick(); chk("s3.t3.fb", framebuf, bar7);        chk_out("s3.t3", 2'd3, 0, 1'b1);
        tick(); chk("s3.t4.fb", framebuf, ~bar7);       chk_out("s3.t4", 2'd3, 0, 1'b0);

        // clamp: 0 -> default 240, 500 -> 384 (held start restarts)
        brew_secs = 9'd0; sw_start = 1; tick();
        chk_out("clamp0", 2'd1, 240, 1'b0);
        brew_secs = 9'd500; tick(); sw_start = 0;
        chk_out("clamp500", 2'd1, 384, 1'b0);
        chk("clamp500.fb", framebuf, '0);

        // full-length run: all-ones on DONE entry, then blink
        ticks(383);
        chk_out("full.383", 2'd1, 1, 1'b0);
        tick(); chk("full.done.fb", framebuf, ones); chk_out("full.done", 2'd3, 0, 1'b1);
        tick(); chk("full.blink0", framebuf, '0);    chk_out("full.b0", 2'd3, 0, 1'b0);
        tick(); chk("full.blink1", framebuf, ones);

        // pause at elapsed 4, hold 10 cycles, resume
        brew_secs = 9'd20; sw_start = 1; tick(); sw_start = 0;
        ticks(4);
        chk_out("p.e4", 2'd1, 16, 1'b0);
        sw_pause = 1; tick(); sw_pause = 0;
`ifdef BREW_TIMER_PAUSE_EN
        chk_out("p.in", 2'd2, 16, 1'b0);
        ticks(10); chk_out("p.hold", 2'd2, 16, 1'b0);
        chk("p.hold.fb", framebuf, FB_BITS'(15));
        sw_pause = 1; tick(); sw_pause = 0;
        chk_out("p.out", 2'd1, 16, 1'b0);
        tick(); chk_out("p.run", 2'd1, 15, 1'b0);
`else
        chk_out("p.in", 2'd1, 15, 1'b0);
        ticks(10); chk_out("p.hold", 2'd1, 5, 1'b0);
        sw_pause = 1; tick(); sw_pause = 0;
        chk_out("p.out", 2'd1, 4, 1'b0);
        tick(); chk_out("p.run", 2'd1, 3, 1'b0);
`endif

        // start + stop together: stop wins
        sw_start = 1; sw_stop = 1; tick(); sw_start = 0; sw_stop = 0;
        chk_out("stop", 2'd0, 0, 1'b0);
        chk("stop.fb", framebuf, '0);
        tick(); chk_out("stop.idle", 2'd0, 0, 1'b0);

        // restart from DONE
        brew_secs = 9'd2; sw_start = 1; tick(); sw_start = 0;
        ticks(2); chk_out("r.done", 2'd3, 0, 1'b1);
        brew_secs = 9'd5; sw_start = 1; tick(); sw_start = 0;
        chk_out("r.start", 2'd1, 5, 1'b0);
        chk("r.start.fb", framebuf, '0);
        tick(); chk_out("r.run", 2'd1, 4, 1'b0);
        chk("r.run.fb", framebuf, FB_BITS'(1));

        // asynchronous reset mid-brew at elapsed 5
        brew_secs = 9'd10; sw_start = 1; tick(); sw_start = 0;
        ticks(5); chk_out("ar.e5", 2'd1, 5, 1'b0);
        #1 nrst = 1'b0;
        #1;
        chk_out("ar", 2'd0, 0, 1'b0);
        chk("ar.fb", framebuf, '0);
        @(negedge clk); nrst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/brew_timer.md
Name: brew_timer

Overview:
- Parametrised successor to the single-preset tea timer.
- Counts seconds on a 1 Hz clock toward a runtime-selectable brew duration.
- Drives a thermometer-style progress bar into the LED framebuffer, then blinks the whole framebuffer when finished.
- Adds explicit states, pause/resume, a remaining-time output and a one-cycle done pulse for a buzzer driver.

Parameters:
- FB_BITS, 384: framebuffer width in LEDs; also the maximum brew duration in seconds.
- CNT_W, 9: width of the elapsed, target and remaining counters; must satisfy 2**CNT_W > FB_BITS.
- DEFAULT_SECS, 240: duration used when brew_secs is 0.

Ports:
- clk  in  1  1 Hz timing clock; all state on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- sw_start  in  1  level; start/restart brewing.
- sw_stop  in  1  level; abort to idle.
- sw_pause  in  1  level; toggle pause (see Optional Feature).
- brew_secs  in  CNT_W  requested duration, sampled only in a start cycle.
- framebuf  out  FB_BITS  LED image.
- state  out  2  current state encoding.
- remaining  out  CNT_W  target minus elapsed.
- done_pulse  out  1  high for exactly one cycle on entry to DONE.

Behaviour:
- Reset (nrst low, asynchronous): all outputs reset as follows.
  - state = IDLE, framebuf = 0, remaining = 0, done_pulse = 0.
  - Internal elapsed = 0, target = 0.
- States: IDLE=0, BREW=1, PAUSE=2, DONE=3.
- Priority per cycle: sw_stop > sw_start > sw_pause > normal progression.
- sw_stop in any state:
  - state = IDLE; framebuf, elapsed, remaining, target cleared; done_pulse = 0.
- sw_start in any state (no stop):
  - Target clamp: target = DEFAULT_SECS if brew_secs == 0; FB_BITS if brew_secs > FB_BITS; otherwise brew_secs.
  - elapsed = 0, framebuf = 0, remaining = target, state = BREW.
  - A held start restarts every cycle.
- BREW, no switch active:
  - elapsed += 1; remaining -= 1.
  - framebuf shifts left one place, inserting 1 at bit 0, so bits [elapsed-1:0] are lit.
  - If the new elapsed == target: state = DONE and done_pulse = 1 in that same registered cycle.
  - Latency: start cycle at t0 -> DONE and done_pulse visible after edge t0+target.
- BREW + sw_pause -> PAUSE. Counters and framebuf frozen.
- PAUSE + sw_pause -> BREW. Counting resumes on the following cycle.
- PAUSE without sw_pause: hold.
- A pause level held high toggles every cycle; an upstream debouncer/edge detector supplies pulses.
- DONE:
  - framebuf inverts every cycle (all-ones/all-zeros, 0.5 Hz blink). The first DONE cycle shows all-ones when target == FB_BITS, otherwise the partial bar.
  - remaining = 0; sticky until start or stop.
  - sw_pause ignored in IDLE and DONE.
- done_pulse is 0 in every cycle except the entry to DONE.
- Counters never wrap: elapsed is bounded by target ≤ FB_BITS.

Optional Feature:
- Macro BREW_TIMER_PAUSE_EN.
  - Defined: sw_pause behaves as above.
  - Undefined: sw_pause is ignored, PAUSE is unreachable, and its logic is not synthesised. The port remains for pin compatibility.

Decomposition:
- Package brew_timer_pkg holds:
  - state enum typedef (IDLE, BREW, PAUSE, DONE) and its 2-bit width;
  - a default FB_BITS constant (384).
- One sub-module, brew_timer_fb. It owns framebuf with commands clear / shift-in-one / invert / hold, issued by the FSM.

Test Plan:
- Reset mid-BREW (elapsed = 5) -> all outputs 0 immediately (asynchronous), state IDLE.
- Start with brew_secs = 3 -> framebuf 0x1, 0x3, 0x7 on the next three edges; DONE with done_pulse on the third edge only; remaining 3->0.
- Start with brew_secs = 0, then with 500 -> target 240, then 384; remaining equals target in the cycle after start.
- brew_secs = 384 run to completion -> framebuf all-ones on DONE entry, then alternating all-zeros/all-ones each cycle.
- Pulse sw_pause at elapsed = 4, hold 10 cycles, pulse again -> elapsed stays 4 while paused, resumes to 5 on the next cycle. With the macro undefined, elapsed continues uninterrupted.
- Assert sw_start and sw_stop together mid-BREW -> IDLE, framebuf 0. Start during DONE -> clean restart to BREW with elapsed 0.
